// File: rtl/i2c_reg_bank_if.sv
// Register-bus interface for i2c_reg_bank: write/read strobes, addresses and read data.
// Signal names are written from the register bank's (slave) point of view.
interface i2c_reg_bank_if;
  logic       i_wr_ena;
  logic [5:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic       i_rd_ena;
  logic [5:0] i_rd_addr;
  logic [7:0] o_rd_data;

  modport master (
    output i_wr_ena, i_wr_addr, i_wr_data, i_rd_ena, i_rd_addr,
    input  o_rd_data
  );

  modport slave (
    input  i_wr_ena, i_wr_addr, i_wr_data, i_rd_ena, i_rd_addr,
    output o_rd_data
  );
endinterface

// File: rtl/i2c_reg_bank.sv
// I2C controller register bank (ADR, FDR, CR, SR, DR, DFSRR) with registered control outputs.
// Optional feature: define I2C_REG_DFSRR_EN to implement the DFSRR filter-rate register at 0x14.
module i2c_reg_bank (
  input  logic                  i_sysclk,
  input  logic                  i_reset_n,
  i2c_reg_bank_if.slave         bus,
  output logic [6:0]            o_adr,
  output logic [5:0]            o_fdr,
  output logic                  o_men,
  output logic                  o_mien,
  output logic                  o_msta,
  output logic                  o_mtx,
  output logic                  o_txak,
  output logic                  o_bcst,
  output logic [5:0]            o_dfsr,
  output logic                  o_rsta,
  output logic [7:0]            o_tx_data,
  output logic                  o_dr_wr,
  output logic                  o_dr_rd,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_mcf,
  input  logic                  i_maas,
  input  logic                  i_mbb,
  input  logic                  i_srw,
  input  logic                  i_rxak,
  input  logic                  i_bcstm,
  input  logic                  i_mif_set,
  input  logic                  i_mal_set,
  input  logic                  i_msta_clr,
  output logic                  o_irq
);

  localparam logic [5:0] A_ADR   = 6'h00;
  localparam logic [5:0] A_FDR   = 6'h04;
  localparam logic [5:0] A_CR    = 6'h08;
  localparam logic [5:0] A_SR    = 6'h0C;
  localparam logic [5:0] A_DR    = 6'h10;
  localparam logic [5:0] A_DFSRR = 6'h14;
  localparam logic [5:0] DFSR_RST = 6'h10;

  logic [6:0] adr_q, adr_d;
  logic [5:0] fdr_q, fdr_d;
  logic       men_q, men_d, mien_q, mien_d, msta_q, msta_d;
  logic       mtx_q, mtx_d, txak_q, txak_d, bcst_q, bcst_d;
  logic       mif_q, mif_d, mal_q, mal_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rsta_q, rsta_d, dr_wr_q, dr_wr_d, dr_rd_q, dr_rd_d, irq_q, irq_d;
  logic [7:0] rd_mux_s;
  logic       wr_cr_s, wr_sr_s, wr_dr_s;
`ifdef I2C_REG_DFSRR_EN
  logic [5:0] dfsr_q, dfsr_d;
`endif

  // Read mux sees pre-write state, so a same-edge read returns the old value.
  always_comb begin
    rd_mux_s = 8'h00;
    case (bus.i_rd_addr)
      A_ADR:   rd_mux_s = {adr_q, 1'b0};
      A_FDR:   rd_mux_s = {2'b00, fdr_q};
      A_CR:    rd_mux_s = {men_q, mien_q, msta_q, mtx_q, txak_q, 1'b0, 1'b0, bcst_q};
      A_SR:    rd_mux_s = {i_mcf, i_maas, i_mbb, mal_q, i_bcstm, i_srw, mif_q, i_rxak};
      A_DR:    rd_mux_s = i_rx_data;
`ifdef I2C_REG_DFSRR_EN
      A_DFSRR: rd_mux_s = {2'b00, dfsr_q};
`endif
      default: rd_mux_s = 8'h00;
    endcase
  end

  // Next-state logic for every register and pulse output.
  always_comb begin
    wr_cr_s   = bus.i_wr_ena && (bus.i_wr_addr == A_CR);
    wr_sr_s   = bus.i_wr_ena && (bus.i_wr_addr == A_SR);
    wr_dr_s   = bus.i_wr_ena && (bus.i_wr_addr == A_DR);
    adr_d     = adr_q;
    fdr_d     = fdr_q;
    tx_data_d = tx_data_q;
`ifdef I2C_REG_DFSRR_EN
    dfsr_d    = dfsr_q;
`endif
    if (bus.i_wr_ena && (bus.i_wr_addr == A_ADR)) begin
      adr_d = bus.i_wr_data[7:1];
    end else if (bus.i_wr_ena && (bus.i_wr_addr == A_FDR)) begin
      fdr_d = bus.i_wr_data[5:0];
`ifdef I2C_REG_DFSRR_EN
    end else if (bus.i_wr_ena && (bus.i_wr_addr == A_DFSRR)) begin
      dfsr_d = bus.i_wr_data[5:0];
`endif
    end else if (wr_dr_s) begin
      tx_data_d = bus.i_wr_data;
    end else begin
      adr_d = adr_q;
    end

    if (wr_cr_s) begin
      men_d  = bus.i_wr_data[7];
      mien_d = bus.i_wr_data[6];
      mtx_d  = bus.i_wr_data[4];
      txak_d = bus.i_wr_data[3];
      bcst_d = bus.i_wr_data[0];
    end else begin
      men_d  = men_q;
      mien_d = mien_q;
      mtx_d  = mtx_q;
      txak_d = txak_q;
      bcst_d = bcst_q;
    end

    // The core's arbitration-loss clear beats a simultaneous CR write.
    if (i_msta_clr) begin
      msta_d = 1'b0;
    end else if (wr_cr_s) begin
      msta_d = bus.i_wr_data[5];
    end else begin
      msta_d = msta_q;
    end
    rsta_d = wr_cr_s && bus.i_wr_data[2] && msta_q;

    if (i_mif_set) begin
      mif_d = 1'b1;
    end else if (wr_sr_s && !bus.i_wr_data[1]) begin
      mif_d = 1'b0;
    end else begin
      mif_d = mif_q;
    end
    if (i_mal_set) begin
      mal_d = 1'b1;
    end else if (wr_sr_s && !bus.i_wr_data[4]) begin
      mal_d = 1'b0;
    end else begin
      mal_d = mal_q;
    end

    if (bus.i_rd_ena) begin
      rd_data_d = rd_mux_s;
    end else begin
      rd_data_d = rd_data_q;
    end
    dr_rd_d = bus.i_rd_ena && (bus.i_rd_addr == A_DR);
    dr_wr_d = wr_dr_s;
    irq_d   = mien_q && mif_q;
  end

  // State and registered outputs; reset aborts any in-flight access.
  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      adr_q     <= 7'h00;
      fdr_q     <= 6'h00;
      men_q     <= 1'b0;
      mien_q    <= 1'b0;
      msta_q    <= 1'b0;
      mtx_q     <= 1'b0;
      txak_q    <= 1'b0;
      bcst_q    <= 1'b0;
      mif_q     <= 1'b0;
      mal_q     <= 1'b0;
      tx_data_q <= 8'h00;
      rd_data_q <= 8'h00;
      rsta_q    <= 1'b0;
      dr_wr_q   <= 1'b0;
      dr_rd_q   <= 1'b0;
      irq_q     <= 1'b0;
`ifdef I2C_REG_DFSRR_EN
      dfsr_q    <= DFSR_RST;
`endif
    end else begin
      adr_q     <= adr_d;
      fdr_q     <= fdr_d;
      men_q     <= men_d;
      mien_q    <= mien_d;
      msta_q    <= msta_d;
      mtx_q     <= mtx_d;
      txak_q    <= txak_d;
      bcst_q    <= bcst_d;
      mif_q     <= mif_d;
      mal_q     <= mal_d;
      tx_data_q <= tx_data_d;
      rd_data_q <= rd_data_d;
      rsta_q    <= rsta_d;
      dr_wr_q   <= dr_wr_d;
      dr_rd_q   <= dr_rd_d;
      irq_q     <= irq_d;
`ifdef I2C_REG_DFSRR_EN
      dfsr_q    <= dfsr_d;
`endif
    end
  end

  assign o_adr         = adr_q;
  assign o_fdr         = fdr_q;
  assign o_men         = men_q;
  assign o_mien        = mien_q;
  assign o_msta        = msta_q;
  assign o_mtx         = mtx_q;
  assign o_txak        = txak_q;
  assign o_bcst        = bcst_q;
  assign o_rsta        = rsta_q;
  assign o_tx_data     = tx_data_q;
  assign o_dr_wr       = dr_wr_q;
  assign o_dr_rd       = dr_rd_q;
  assign o_irq         = irq_q;
  assign bus.o_rd_data = rd_data_q;
`ifdef I2C_REG_DFSRR_EN
  assign o_dfsr        = dfsr_q;
`else
  assign o_dfsr        = DFSR_RST;
`endif

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: read results are scored through an expected-value queue.
module tb_i2c_reg_bank;
  logic       clk;
  logic       rst_n;
  logic [6:0] o_adr;
  logic [5:0] o_fdr, o_dfsr;
  logic       o_men, o_mien, o_msta, o_mtx, o_txak, o_bcst;
  logic       o_rsta, o_dr_wr, o_dr_rd, o_irq;
  logic [7:0] o_tx_data, i_rx_data;
  logic       i_mcf, i_maas, i_mbb, i_srw, i_rxak, i_bcstm;
  logic       i_mif_set, i_mal_set, i_msta_clr;

  int n_checks = 0;
  int n_errors = 0;
  int rsta_cnt = 0;
  int dr_wr_cnt = 0;
  int dr_rd_cnt = 0;
  int snap;
  logic [7:0] exp_q[$];

`ifdef I2C_REG_DFSRR_EN
  localparam logic [7:0] DFSRR_RST_RD = 8'h10;
  localparam logic [7:0] DFSRR_WR_RD  = 8'h3F;
  localparam logic [5:0] DFSR_WR_OUT  = 6'h3F;
`else
  localparam logic [7:0] DFSRR_RST_RD = 8'h00;
  localparam logic [7:0] DFSRR_WR_RD  = 8'h00;
  localparam logic [5:0] DFSR_WR_OUT  = 6'h10;
`endif

  i2c_reg_bank_if bus_if ();

  i2c_reg_bank dut (
    .i_sysclk(clk), .i_reset_n(rst_n), .bus(bus_if.slave),
    .o_adr(o_adr), .o_fdr(o_fdr), .o_men(o_men), .o_mien(o_mien), .o_msta(o_msta),
    .o_mtx(o_mtx), .o_txak(o_txak), .o_bcst(o_bcst), .o_dfsr(o_dfsr),
    .o_rsta(o_rsta), .o_tx_data(o_tx_data), .o_dr_wr(o_dr_wr), .o_dr_rd(o_dr_rd),
    .i_rx_data(i_rx_data), .i_mcf(i_mcf), .i_maas(i_maas), .i_mbb(i_mbb),
    .i_srw(i_srw), .i_rxak(i_rxak), .i_bcstm(i_bcstm), .i_mif_set(i_mif_set),
    .i_mal_set(i_mal_set), .i_msta_clr(i_msta_clr), .o_irq(o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_rsta)  rsta_cnt  = rsta_cnt + 1;
    if (o_dr_wr) dr_wr_cnt = dr_wr_cnt + 1;
    if (o_dr_rd) dr_rd_cnt = dr_rd_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_if.i_wr_ena  = 1'b1;
    bus_if.i_wr_addr = addr;
    bus_if.i_wr_data = data;
    @(posedge clk);
    #1;
    bus_if.i_wr_ena  = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [5:0] addr, input logic [7:0] exp);
    @(negedge clk);
    bus_if.i_rd_ena  = 1'b1;
    bus_if.i_rd_addr = addr;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus_if.i_rd_ena  = 1'b0;
    check_value(tag, {24'h0, bus_if.o_rd_data}, {24'h0, exp_q.pop_front()});
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.i_wr_ena = 1'b0; bus_if.i_wr_addr = 6'h00; bus_if.i_wr_data = 8'h00;
    bus_if.i_rd_ena = 1'b0; bus_if.i_rd_addr = 6'h00;
    i_rx_data = 8'h5A;
    i_mcf = 1'b1; i_maas = 1'b0; i_mbb = 1'b1; i_srw = 1'b0; i_rxak = 1'b1; i_bcstm = 1'b1;
    i_mif_set = 1'b0; i_mal_set = 1'b0; i_msta_clr = 1'b0;
    idle(3);
    check_value("rst_irq", {31'h0, o_irq}, 32'h0);
    check_value("rst_tx", {24'h0, o_tx_data}, 32'h0);
    check_value("rst_dfsr", {26'h0, o_dfsr}, 32'h10);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values of all six registers; SR = live 1,0,1,mal0,1,0,mif0,1
    do_read("rd_adr0", 6'h00, 8'h00);
    do_read("rd_fdr0", 6'h04, 8'h00);
    do_read("rd_cr0", 6'h08, 8'h00);
    do_read("rd_sr0", 6'h0C, 8'hA9);
    snap = dr_rd_cnt;
    do_read("rd_dr0", 6'h10, 8'h5A);
    do_read("rd_dfsrr0", 6'h14, DFSRR_RST_RD);
    check_value("dr_rd_pulse0", snap + 1, dr_rd_cnt);
    check_value("irq0", {31'h0, o_irq}, 32'h0);

    // RSTA ignored while MSTA=0, then pulses once
    snap = rsta_cnt;
    do_write(6'h08, 8'hE4);
    do_read("rd_cr_e0a", 6'h08, 8'hE0);
    check_value("rsta_none", rsta_cnt, snap);
    check_value("msta_set", {31'h0, o_msta}, 32'h1);
    do_write(6'h08, 8'hE4);
    check_value("rsta_high", {31'h0, o_rsta}, 32'h1);
    idle(2);
    check_value("rsta_once", rsta_cnt, snap + 1);
    do_read("rd_cr_e0b", 6'h08, 8'hE0);

    // Read-only / reserved bits
    do_write(6'h00, 8'hA5);
    do_read("rd_adr", 6'h00, 8'hA4);
    check_value("o_adr", {25'h0, o_adr}, 32'h52);
    do_write(6'h04, 8'hFF);
    do_read("rd_fdr", 6'h04, 8'h3F);
    do_write(6'h3C, 8'h55);
    do_read("rd_unmapped", 6'h3C, 8'h00);

    // Interrupt flag and IRQ timing (MIEN already 1)
    @(negedge clk); i_mif_set = 1'b1;
    @(posedge clk); #1; i_mif_set = 1'b0;
    check_value("irq_lag", {31'h0, o_irq}, 32'h0);
    idle(1);
    check_value("irq_set", {31'h0, o_irq}, 32'h1);
    do_read("rd_sr_mif", 6'h0C, 8'hAB);
    do_write(6'h0C, 8'h00);
    do_read("rd_sr_clr", 6'h0C, 8'hA9);
    check_value("irq_clr", {31'h0, o_irq}, 32'h0);
    @(negedge clk);
    i_mif_set = 1'b1;
    bus_if.i_wr_ena = 1'b1; bus_if.i_wr_addr = 6'h0C; bus_if.i_wr_data = 8'hFD;
    @(posedge clk); #1;
    i_mif_set = 1'b0; bus_if.i_wr_ena = 1'b0;
    do_read("rd_sr_setwin", 6'h0C, 8'hAB);

    // Arbitration-lost flag: write-1 keeps, write-0 clears
    @(negedge clk); i_mal_set = 1'b1;
    @(posedge clk); #1; i_mal_set = 1'b0;
    do_write(6'h0C, 8'hFF);
    do_read("rd_sr_mal", 6'h0C, 8'hBB);
    do_write(6'h0C, 8'hED);
    do_read("rd_sr_mal_clr", 6'h0C, 8'hA9);

    // Data register
    snap = dr_wr_cnt;
    do_write(6'h10, 8'h3C);
    check_value("tx_data", {24'h0, o_tx_data}, 32'h3C);
    idle(2);
    check_value("dr_wr_once", dr_wr_cnt, snap + 1);
    i_rx_data = 8'h96;
    snap = dr_rd_cnt;
    do_read("rd_dr", 6'h10, 8'h96);
    idle(2);
    check_value("dr_rd_once", dr_rd_cnt, snap + 1);

    // MSTA clear beats a simultaneous CR write that sets it
    do_write(6'h08, 8'h80);
    @(negedge clk);
    i_msta_clr = 1'b1;
    bus_if.i_wr_ena = 1'b1; bus_if.i_wr_addr = 6'h08; bus_if.i_wr_data = 8'hA0;
    @(posedge clk); #1;
    i_msta_clr = 1'b0; bus_if.i_wr_ena = 1'b0;
    do_read("rd_cr_mstaclr", 6'h08, 8'h80);

    // Same-edge read and write of one register returns the old value
    @(negedge clk);
    bus_if.i_wr_ena = 1'b1; bus_if.i_wr_addr = 6'h00; bus_if.i_wr_data = 8'h12;
    bus_if.i_rd_ena = 1'b1; bus_if.i_rd_addr = 6'h00;
    exp_q.push_back(8'hA4);
    @(posedge clk); #1;
    bus_if.i_wr_ena = 1'b0; bus_if.i_rd_ena = 1'b0;
    check_value("rd_rw_same", {24'h0, bus_if.o_rd_data}, {24'h0, exp_q.pop_front()});
    do_read("rd_adr_new", 6'h00, 8'h12);

    // Pulses still emitted with MEN=0
    do_write(6'h08, 8'h20);
    snap = rsta_cnt;
    do_write(6'h08, 8'h24);
    idle(2);
    check_value("rsta_men0", rsta_cnt, snap + 1);
    snap = dr_wr_cnt;
    do_write(6'h10, 8'hC3);
    idle(2);
    check_value("dr_wr_men0", dr_wr_cnt, snap + 1);

    // Optional filter-rate register
    do_write(6'h14, 8'hFF);
    do_read("rd_dfsrr", 6'h14, DFSRR_WR_RD);
    check_value("o_dfsr", {26'h0, o_dfsr}, {26'h0, DFSR_WR_OUT});

    // Reset in the middle of a DR write aborts it
    snap = dr_wr_cnt;
    @(negedge clk);
    bus_if.i_wr_ena = 1'b1; bus_if.i_wr_addr = 6'h10; bus_if.i_wr_data = 8'h99;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    bus_if.i_wr_ena = 1'b0;
    #2 rst_n = 1'b1;
    idle(2);
    check_value("rst_abort_pulse", dr_wr_cnt, snap);
    check_value("rst_abort_tx", {24'h0, o_tx_data}, 32'h0);
    check_value("rst_dfsr2", {26'h0, o_dfsr}, 32'h10);
    do_read("rd_cr_rst", 6'h08, 8'h00);
    snap = dr_wr_cnt;
    do_write(6'h10, 8'h77);
    idle(2);
    check_value("post_rst_wr", dr_wr_cnt, snap + 1);
    check_value("post_rst_tx", {24'h0, o_tx_data}, 32'h77);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/i2c_reg_bank.md
I2C_REG_BANK -- requirements
Module: i2c_reg_bank

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port `i_sysclk`, input, 1 bit: system clock, all state on rising edge.
REQ-003 Port `i_reset_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 Ports `i_wr_ena` in 1, `i_wr_addr` in 6, `i_wr_data` in 8: register write strobe, address, data.
REQ-005 Ports `i_rd_ena` in 1, `i_rd_addr` in 6: register read strobe, address; `o_rd_data` out 8: registered read data.
REQ-006 Control outputs SHALL be: `o_adr` out 7 (slave address), `o_fdr` out 6 (frequency divider), `o_men`, `o_mien`, `o_msta`, `o_mtx`, `o_txak`, `o_bcst` out 1 each, and `o_dfsr` out 6 (filter sample rate).
REQ-007 Data-path ports SHALL be: `o_rsta` out 1 (one-cycle pulse), `o_tx_data` out 8, `o_dr_wr` out 1 (pulse), `o_dr_rd` out 1 (pulse), `i_rx_data` in 8.
REQ-008 Status inputs, all 1 bit: `i_mcf`, `i_maas`, `i_mbb`, `i_srw`, `i_rxak`, `i_bcstm` are levels; `i_mif_set`, `i_mal_set`, `i_msta_clr` are one-cycle pulses.
REQ-009 `o_irq` SHALL be a 1-bit output, the registered AND of MIEN and MIF.

Function
REQ-010 Register map SHALL be: 0x00 ADR, 0x04 FDR, 0x08 CR, 0x0C SR, 0x10 DR, 0x14 DFSRR; all other addresses SHALL read 0x00 and ignore writes.
REQ-011 A write SHALL take effect on the rising edge where `i_wr_ena`=1; address and data are sampled on that same edge.
REQ-012 A read SHALL load `o_rd_data` on the edge where `i_rd_ena`=1, valid from the next cycle, and SHALL hold until the next read.
REQ-013 ADR SHALL be bits [7:1], RW, with bit 0 reading 0; FDR SHALL be bits [5:0], RW, with bits [7:6] reading 0.
REQ-014 CR bit map: MEN[7], MIEN[6], MSTA[5], MTX[4], TXAK[3], RSTA[2], BCST[0]; bit 1 SHALL read 0.
REQ-015 RSTA SHALL not be stored: writing 1 SHALL pulse `o_rsta` for exactly one cycle, and the bit SHALL always read 0.
REQ-016 A write of RSTA=1 while MSTA=0 SHALL be ignored.
REQ-017 `i_msta_clr` SHALL clear MSTA; if a CR write sets MSTA on the same edge, the clear SHALL win.
REQ-018 SR bit map: MCF[7], MAAS[6], MBB[5], MAL[4], BCSTM[3], SRW[2], MIF[1], RXAK[0].
REQ-019 SR bits 7, 6, 5, 3, 2 and 0 SHALL read the live inputs; writes to them SHALL be ignored.
REQ-020 MIF and MAL SHALL be sticky: set by `i_mif_set` / `i_mal_set`, cleared by writing 0 to the bit, and unchanged by writing 1.
REQ-021 When a set pulse and a clearing write occur on the same edge, set SHALL win.
REQ-022 A DR write SHALL load `o_tx_data` and pulse `o_dr_wr` for one cycle.
REQ-023 A DR read SHALL return `i_rx_data` and pulse `o_dr_rd` for one cycle.
REQ-024 When a read and a write hit the same register on the same edge, both SHALL execute and the read SHALL return the pre-write value.
REQ-025 With MEN=0, CR/SR/DR SHALL remain accessible; `o_dr_wr` and `o_rsta` SHALL still pulse, since gating is the core's duty.
REQ-026 `o_irq` SHALL assert one cycle after both MIEN and MIF are 1, and deassert one cycle after either becomes 0.

Reset
REQ-027 On `i_reset_n`=0, the block SHALL asynchronously clear ADR, FDR, CR, MIF, MAL, `o_tx_data`, `o_rd_data`, `o_rsta`, `o_dr_wr`, `o_dr_rd` and `o_irq` to 0, and set DFSRR to 0x10.
REQ-028 Reset asserted mid-access SHALL abort the access with no pulse emitted, and the first access after deassertion SHALL behave normally.

Configuration
REQ-029 Macro `I2C_REG_DFSRR_EN`, when defined, SHALL implement DFSRR at 0x14 as RW [5:0] with reset 0x10, driving `o_dfsr`.
REQ-030 When `I2C_REG_DFSRR_EN` is undefined, 0x14 SHALL read 0x00, ignore writes, and `o_dfsr` SHALL be the constant 0x10.

Verification
REQ-031 Reset, then read all six addresses -> 0x00,0x00,0x00,SR live,`i_rx_data`,0x10 (0x00 without macro); `o_irq`=0.
REQ-032 Write CR=0xE4 with MSTA=0 before the write -> CR reads 0xE0 and `o_rsta` does not pulse; write CR=0xE4 again -> one `o_rsta` pulse, CR reads 0xE0.
REQ-033 Write ADR=0xA5 -> reads 0xA4; write FDR=0xFF -> reads 0x3F; write 0x3C=0x55 -> reads 0x00.
REQ-034 MIEN=1, pulse `i_mif_set` -> SR[1]=1 and `o_irq`=1 after one cycle; write SR=0x00 -> MIF=0 and `o_irq`=0; write SR=0xFD on the same edge as `i_mif_set` -> MIF stays 1.
REQ-035 Write DR=0x3C -> `o_tx_data`=0x3C with a single `o_dr_wr` pulse; with `i_rx_data`=0x96, read DR -> 0x96 with a single `o_dr_rd` pulse.
REQ-036 Pulse `i_msta_clr` on the same edge as a CR write of 0xA0 -> MSTA=0, CR reads 0x80.
